// File: rtl/la_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | la_pkg : shared types/constants for the logic-analyzer readout path  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package la_pkg;

    localparam int unsigned NUM_CH = 5;

    typedef enum logic [2:0] {
        DS_IDLE    = 3'd0,
        DS_RD      = 3'd1,
        DS_LD      = 3'd2,
        DS_WAIT_TX = 3'd3,
        DS_DONE    = 3'd4
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/dump_ctrl_wrap_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wrap_cnt : loadable address counter that wraps from ENTRIES-1 to 0   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wrap_cnt #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [LOG2-1:0] load_val,
    input  logic            inc,
    output logic [LOG2-1:0] cnt
);

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    logic [LOG2-1:0] cnt_d;
    logic [LOG2-1:0] cnt_q;

    // Out-of-range load values fall back to the bottom of the buffer.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_val > LAST) ? '0 : load_val;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/dump_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dump_ctrl : streams one channel's circular capture RAM to the UART   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dump_ctrl
    import la_pkg::*;
#(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump_en,
    input  logic [2:0]      dump_chan,
    input  logic            capture_done,
    input  logic [LOG2-1:0] waddr,
    output logic [LOG2-1:0] raddr,
    output logic [2:0]      ch_sel,
    input  logic [7:0]      rdata,
    output logic [7:0]      tx_data,
    output logic            trmt,
    input  logic            tx_done,
    output logic            busy,
    output logic            dump_done,
    output logic            clr_capture_done,
    output logic            dump_rej
);

    localparam logic [LOG2-1:0] LAST     = LOG2'(ENTRIES - 1);
    localparam logic [2:0]      CH_LIMIT = 3'(NUM_CH);

    dump_state_t     state_d, state_q;
    logic [LOG2-1:0] cnt_d, cnt_q;
    logic [2:0]      ch_sel_d, ch_sel_q;
    logic [7:0]      tx_data_d, tx_data_q;
    logic            trmt_d, trmt_q;
    logic            busy_d, busy_q;
    logic            dump_done_d, dump_done_q;
    logic            dump_rej_d, dump_rej_q;
    logic            raddr_load;
    logic            raddr_inc;
    logic            accept;

    assign accept = dump_en && capture_done && (dump_chan < CH_LIMIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_sel_d    = ch_sel_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        dump_done_d = 1'b0;
        dump_rej_d  = 1'b0;
        raddr_load  = 1'b0;
        raddr_inc   = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (dump_en) begin
                    if (accept) begin
                        ch_sel_d   = dump_chan;
                        cnt_d      = '0;
                        raddr_load = 1'b1;
                        state_d    = DS_RD;
                    end else begin
                        dump_rej_d = 1'b1;
                    end
                end
            end
            DS_RD: begin
                state_d = DS_LD;
            end
            DS_LD: begin
                tx_data_d = rdata;
                trmt_d    = 1'b1;
                state_d   = DS_WAIT_TX;
            end
            DS_WAIT_TX: begin
                if (tx_done) begin
                    if (cnt_q == LAST) begin
                        state_d = DS_DONE;
                    end else begin
                        cnt_d     = cnt_q + LOG2'(1);
                        raddr_inc = 1'b1;
                        state_d   = DS_RD;
                    end
                end
            end
            DS_DONE: begin
                dump_done_d = 1'b1;
                state_d     = DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
        // Registered so busy lines up with the state it describes.
        busy_d = (state_d != DS_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DS_IDLE;
            cnt_q       <= '0;
            ch_sel_q    <= '0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            busy_q      <= 1'b0;
            dump_done_q <= 1'b0;
            dump_rej_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_sel_q    <= ch_sel_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            busy_q      <= busy_d;
            dump_done_q <= dump_done_d;
            dump_rej_q  <= dump_rej_d;
        end
    end

    wrap_cnt #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_raddr_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (raddr_load),
        .load_val (waddr),
        .inc      (raddr_inc),
        .cnt      (raddr)
    );

    assign ch_sel           = ch_sel_q;
    assign tx_data          = tx_data_q;
    assign trmt             = trmt_q;
    assign busy             = busy_q;
    assign dump_done        = dump_done_q;
    assign clr_capture_done = dump_done_q;
    assign dump_rej         = dump_rej_q;

endmodule
`default_nettype wire

// File: tb/tb_dump_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dump_ctrl : vector table, corner sequences and random dumps       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dump_ctrl;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
    localparam int NCH     = 5;
    localparam int BUDGET  = ENTRIES * 16 + 200;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            dump_en;
    logic [2:0]      dump_chan;
    logic            capture_done;
    logic [LOG2-1:0] waddr;
    logic [LOG2-1:0] raddr;
    logic [2:0]      ch_sel;
    logic [7:0]      rdata = 8'h00;
    logic [7:0]      tx_data;
    logic            trmt;
    logic            tx_done = 1'b0;
    logic            busy;
    logic            dump_done;
    logic            clr_capture_done;
    logic            dump_rej;

    dump_ctrl #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dump_en          (dump_en),
        .dump_chan        (dump_chan),
        .capture_done     (capture_done),
        .waddr            (waddr),
        .raddr            (raddr),
        .ch_sel           (ch_sel),
        .rdata            (rdata),
        .tx_data          (tx_data),
        .trmt             (trmt),
        .tx_done          (tx_done),
        .busy             (busy),
        .dump_done        (dump_done),
        .clr_capture_done (clr_capture_done),
        .dump_rej         (dump_rej)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int ch;
        bit busy;
        int cyc;
    } byte_rec_t;

    typedef struct {
        bit cd;
        int ch;
        int w;
        bit acc;
        int first;
    } vec_t;

    logic [7:0] mem [NCH][ENTRIES];
    byte_rec_t  trq[$];
    int         txd_q[$];
    int         done_q[$];
    int         clr_q[$];
    int         rej_q[$];
    int         busy_hi = 0;
    int         cyc = 0;
    int         uart_cnt = 0;
    int         uart_lat = 5;
    bit         rand_lat = 1'b0;
    bit         spur_arm = 1'b0;
    bit         spur_now = 1'b0;
    int         spur_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture RAM: synchronous read, one clock of latency.
    always @(posedge clk) begin
        if (int'(ch_sel) < NCH && int'(raddr) < ENTRIES)
            rdata <= mem[int'(ch_sel)][int'(raddr)];
        else
            rdata <= 8'hEE;
    end

    // Output monitor plus UART model answering each trmt after a delay.
    always @(negedge clk) begin
        if (trmt) trq.push_back('{int'(raddr), int'(tx_data), int'(ch_sel), busy, cyc});
        if (dump_done) done_q.push_back(cyc);
        if (clr_capture_done) clr_q.push_back(cyc);
        if (dump_rej) rej_q.push_back(cyc);
        if (busy) busy_hi++;
        tx_done = 1'b0;
        if (!rst_n) begin
            uart_cnt = 0;
            spur_now = 1'b0;
        end else begin
            if (spur_now) begin
                tx_done  = 1'b1;
                spur_now = 1'b0;
                spur_cnt++;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    tx_done = 1'b1;
                    txd_q.push_back(cyc);
                    if (spur_arm) begin
                        spur_arm = 1'b0;
                        spur_now = 1'b1;
                    end
                end
            end
            if (trmt) uart_cnt = rand_lat ? int'($urandom_range(8, 1)) : uart_lat;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start_req(input int w, input int ch, input bit cd, output int rc);
        @(negedge clk);
        trq.delete();
        txd_q.delete();
        done_q.delete();
        clr_q.delete();
        rej_q.delete();
        busy_hi = 0;
        waddr        = w[LOG2-1:0];
        dump_chan    = ch[2:0];
        capture_done = cd;
        dump_en      = 1'b1;
        rc           = cyc;
        @(negedge clk);
        dump_en = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_finished"}, int'(done_q.size() > 0), 1);
        repeat (4) @(negedge clk);
    endtask

    // Expected stream: ENTRIES bytes of channel ch, starting at first, wrapping.
    task automatic check_dump(input string nm, input int first, input int ch, input int rc);
        int bad;
        int ea;
        int last;
        bad = 0;
        chk({nm, "_bytes"}, trq.size(), ENTRIES);
        foreach (trq[k]) begin
            ea = (first + k) % ENTRIES;
            if (trq[k].addr != ea || trq[k].data != int'(mem[ch][ea]) ||
                trq[k].ch != ch || !trq[k].busy)
                bad++;
            if (k > 0 && txd_q.size() >= k && trq[k].cyc - txd_q[k-1] != 3)
                bad++;
        end
        chk({nm, "_byte_errs"}, bad, 0);
        if (trq.size() > 0) begin
            last = trq.size() - 1;
            chk({nm, "_first_addr"}, trq[0].addr, first);
            chk({nm, "_last_addr"}, trq[last].addr, (first + ENTRIES - 1) % ENTRIES);
            chk({nm, "_first_trmt_lat"}, trq[0].cyc - rc, 3);
        end
        chk({nm, "_done_pulses"}, done_q.size(), 1);
        chk({nm, "_clr_pulses"}, clr_q.size(), 1);
        if (done_q.size() > 0 && txd_q.size() > 0) begin
            chk({nm, "_done_lat"}, done_q[0] - txd_q[txd_q.size()-1], 2);
            if (clr_q.size() > 0) chk({nm, "_clr_with_done"}, clr_q[0], done_q[0]);
        end
        chk({nm, "_no_rej"}, rej_q.size(), 0);
        chk({nm, "_idle_after"}, int'(busy), 0);
    endtask

    task automatic run_accepted(input string nm, input int w, input int ch, input int first);
        int rc;
        start_req(w, ch, 1'b1, rc);
        wait_done(nm);
        check_dump(nm, first, ch, rc);
    endtask

    task automatic run_rejected(input string nm, input int w, input int ch, input bit cd);
        int rc;
        start_req(w, ch, cd, rc);
        repeat (8) @(negedge clk);
        chk({nm, "_rej_pulses"}, rej_q.size(), 1);
        if (rej_q.size() > 0) chk({nm, "_rej_lat"}, rej_q[0] - rc, 1);
        chk({nm, "_busy_cycles"}, busy_hi, 0);
        chk({nm, "_trmt_count"}, trq.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   rc;
        int   n;
        int   nb;
        int   w;
        int   ch;
        bit   cd;

        rst_n        = 1'b1;
        dump_en      = 1'b0;
        dump_chan    = 3'd0;
        capture_done = 1'b0;
        waddr        = '0;
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < ENTRIES; a++)
                mem[c][a] = 8'(a);

        #2 rst_n = 1'b0;
        #1;
        chk("reset_raddr", int'(raddr), 0);
        chk("reset_ch_sel", int'(ch_sel), 0);
        chk("reset_tx_data", int'(tx_data), 0);
        chk("reset_trmt", int'(trmt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_dump_done", int'(dump_done), 0);
        chk("reset_clr", int'(clr_capture_done), 0);
        chk("reset_rej", int'(dump_rej), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // capture_done, channel, waddr, accepted, expected first address
        vt[0] = '{1'b1, 2, 100, 1'b1, 100};
        vt[1] = '{1'b1, 0, 383, 1'b1, 383};
        vt[2] = '{1'b0, 1, 5,   1'b0, 0};
        vt[3] = '{1'b1, 5, 0,   1'b0, 0};
        vt[4] = '{1'b1, 7, 9,   1'b0, 0};
        vt[5] = '{1'b1, 4, 450, 1'b1, 0};
        for (int i = 0; i < 6; i++) begin
            if (vt[i].acc && vt[i].cd)
                run_accepted($sformatf("vec%0d", i), vt[i].w, vt[i].ch, vt[i].first);
            else
                run_rejected($sformatf("vec%0d", i), vt[i].w, vt[i].ch, vt[i].cd);
        end

        // Extra request and a stray tx_done during a dump.
        start_req(200, 1, 1'b1, rc);
        n = 0;
        while (trq.size() < 50 && n < BUDGET) begin @(negedge clk); n++; end
        spur_arm = 1'b1;
        while (trq.size() < 100 && n < BUDGET) begin @(negedge clk); n++; end
        waddr     = 9'd10;
        dump_chan = 3'd3;
        dump_en   = 1'b1;
        @(negedge clk);
        dump_en = 1'b0;
        wait_done("noise");
        check_dump("noise", 200, 1, rc);
        chk("noise_spur_issued", spur_cnt, 1);

        // Reset lands while the 11th byte's trmt is high.
        start_req(50, 3, 1'b1, rc);
        n = 0;
        while (!(trmt && trq.size() >= 11) && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_reached_byte11", int'(trq.size() >= 11), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_trmt", int'(trmt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_ch_sel", int'(ch_sel), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        nb = trq.size();
        repeat (4) @(negedge clk);
        chk("rst_no_trmt", trq.size(), nb);
        rst_n = 1'b1;
        run_accepted("redump", 7, 3, 7);

        // Random requests against the acceptance and ordering rules.
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < ENTRIES; a++)
                mem[c][a] = 8'($urandom_range(255, 0));
        rand_lat = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cd = ($urandom_range(5, 0) != 0);
            ch = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 5)) : int'($urandom_range(4, 0));
            w  = int'($urandom_range(511, 0));
            if (cd && ch < NCH)
                run_accepted($sformatf("rnd%0d", i), w, ch, (w >= ENTRIES) ? 0 : w);
            else
                run_rejected($sformatf("rnd%0d", i), w, ch, cd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dump_ctrl.md
# dump_ctrl

Sequences readout of the capture RAMs after an acquisition completes. On a dump command it reads every stored sample of one selected channel, oldest first. The oldest sample sits at the current capture write address, and reads wrap around the circular buffer. Each byte is handed to the UART transmitter through a trmt/tx_done handshake. It sits between cmd_cfg (command source, capture_done flag), the capture RAM read port and the UART transmitter.

## Interface
- ENTRIES, 384, samples per channel RAM (12288 on DE-0)
- LOG2, 9, address width, log2 of ENTRIES rounded up
- NUM_CH, 5, number of channel RAMs

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active low
- dump_en  in  1  one-clock dump request from cmd_cfg
- dump_chan  in  3  channel to dump, valid with dump_en
- capture_done  in  1  capture_done bit from cmd_cfg
- waddr  in  LOG2  capture write address; equals the oldest-sample address when capture is done
- raddr  out  LOG2  RAM read address
- ch_sel  out  3  RAM read-data mux select
- rdata  in  8  muxed RAM read data, synchronous read, 1-clock latency
- tx_data  out  8  byte to UART
- trmt  out  1  one-clock transmit strobe
- tx_done  in  1  one-clock pulse, UART byte finished
- busy  out  1  dump in progress
- dump_done  out  1  one-clock pulse, last byte finished
- clr_capture_done  out  1  one-clock pulse to cmd_cfg, issued with dump_done
- dump_rej  out  1  one-clock pulse, request refused

## Operation
- States: IDLE, RD, LD, WAIT_TX, DONE. Any unused encoding goes to IDLE.
- IDLE:
  - dump_en && capture_done && dump_chan<NUM_CH: latch ch_sel<=dump_chan and raddr<=waddr, clear cnt, go to RD. If waddr>=ENTRIES, use 0 instead.
  - dump_en otherwise: pulse dump_rej, stay in IDLE.
- RD: raddr held stable while the RAM reads. Go to LD.
- LD: tx_data<=rdata, trmt<=1 (registered, high the next cycle only). Go to WAIT_TX.
- WAIT_TX: wait for tx_done.
  - tx_done with cnt==ENTRIES-1: go to DONE.
  - tx_done otherwise: cnt++, raddr<=(raddr==ENTRIES-1)?0:raddr+1, go to RD.
- DONE: pulse dump_done and clr_capture_done, go to IDLE.
- busy=1 in every state except IDLE.
- dump_en while busy: ignored, no dump_rej.
- tx_done outside WAIT_TX: ignored.
- cnt is LOG2 bits and counts 0..ENTRIES-1. Exactly ENTRIES bytes are sent per dump.
- tx_data and ch_sel hold their values from trmt until the next LD or reset.
- Reset values: raddr=0, ch_sel=0, tx_data=0, trmt=0, busy=0, dump_done=0, clr_capture_done=0, dump_rej=0, state IDLE.
- Reset asserted mid-dump: outputs take their reset values immediately and asynchronously. No further trmt. A later dump restarts from the current waddr.

## Timing
- dump_en is sampled at edge 0. State is RD after edge 0 and LD after edge 1. trmt is high for the cycle after edge 2, i.e. 3 clocks after the request.
- Each subsequent byte: trmt goes high 3 clocks after the sampling edge of the previous tx_done (WAIT_TX→RD, RD→LD, LD→trmt).
- dump_done and clr_capture_done go high 2 clocks after the final tx_done is sampled.
- Total dump length ≈ ENTRIES × (UART byte time + 3) clocks.
- dump_rej goes high in the cycle after dump_en is sampled.

## Structure
- Shared package la_pkg holds the dump_state_t enum and the NUM_CH constant. ENTRIES and LOG2 stay module parameters, matching capture.
- One sub-module: wrap_cnt, a LOG2-bit loadable counter with wrap at ENTRIES-1, used for raddr. cnt is a plain counter inside dump_ctrl.

## Test plan
- ENTRIES=384, waddr=100, dump_chan=2, capture_done=1; UART model returns tx_done 5 clocks after each trmt, and the RAM model returns addr[7:0] as data. Required: 384 trmt pulses; raddr sequence 100..383, then 0..99; tx_data equals raddr[7:0]; ch_sel=2 throughout; a single dump_done and clr_capture_done pulse after the 384th tx_done.
- waddr=383: first raddr=383, second raddr=0. The 384th byte is read from address 382.
- dump_en with capture_done=0, and separately with dump_chan=5: a dump_rej pulse 1 clock later; busy stays 0; no trmt.
- Mid-dump extra dump_en and a spurious tx_done while in RD: both ignored, byte count stays 384, raddr sequence unbroken.
- rst_n asserted after 10 bytes: trmt=0, busy=0 and raddr=0 within the same cycle. A new dump with waddr=7 starts at raddr=7 and sends 384 bytes.
- Cycle check: first trmt exactly 3 clocks after dump_en; dump_done exactly 2 clocks after the final tx_done.
